// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: in-order {pc, instr} FIFO between fetch and decode with flush.
// Define FETCH_QUEUE_BYPASS_EN to pass a pair straight through when the queue is empty.
module fetch_instr_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             fetch_write,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             empty, push, pop, byp;
    assign empty       = count == '0;
    assign fetch_write = count != (PTR_W+1)'(DEPTH);
    always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = empty && in_valid && !flush;
`else
        byp = 1'b0;
`endif
        // a bypassed pair taken by decode in the same cycle is never stored
        push = in_valid && fetch_write && !flush && !(byp && out_ready);
        pop  = !empty && out_ready && !flush;
        out_valid = !empty || byp;
        {out_pc, out_instr} = !empty ? mem[rd_ptr] : byp ? {in_pc, in_instr} : 64'd0;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push && !reset) mem[wr_ptr] <= {in_pc, in_instr};
endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: directed stimulus with a scoreboard checked by an independent monitor.
module tb_fetch_instr_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        fetch_write, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
    int          vectors = 0, miscompares = 0, mcount = 0;
    logic [63:0] exp_q [$];
    bit          last_acc;

    fetch_instr_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .fetch_write(fetch_write), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h1300_0093;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // drives one cycle's inputs, records what the queue must later deliver, returns at negedge
    task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] instr,
                       input bit ordy, input bit fl);
        bit b, acc, pp;
        @(posedge clk); #1;
        in_valid = iv; in_pc = iv ? pc : 32'd0; in_instr = iv ? instr : 32'd0;
        out_ready = ordy; flush = fl;
        last_acc = 1'b0;
        if (reset || fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            b   = BYP && mcount == 0 && iv;
            acc = iv && mcount != DEPTH && !(b && ordy);
            pp  = mcount != 0 && ordy;
            if (acc || (b && ordy)) begin
                exp_q.push_back({pc, instr});
                last_acc = 1'b1;
            end
            mcount = mcount + int'(acc) - int'(pp);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && mcount != 0; k++) idle(1'b1);
        idle(1'b0);
        chk("drain_count", {61'd0, count}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got pc 0x%0h, expected no entry", out_pc);
            end else chk("scoreboard_pair", {out_pc, out_instr}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        reset = 1'b0;
        idle(1'b0);
        chk("reset_count", {61'd0, count}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_pc", {32'd0, out_pc}, 64'd0);
        chk("reset_fetch_write", {63'd0, fetch_write}, 64'd1);

        // single push, then fill to full
        cyc(1'b1, 32'h0, 32'h00A0_0093, 1'b0, 1'b0);
        idle(1'b0);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_pair", {out_pc, out_instr}, {32'h0, 32'h00A0_0093});
        chk("t1_count", {61'd0, count}, 64'd1);
        cyc(1'b1, 32'h4, ins(32'h4), 1'b0, 1'b0);
        cyc(1'b1, 32'h8, ins(32'h8), 1'b0, 1'b0);
        cyc(1'b1, 32'hC, ins(32'hC), 1'b0, 1'b0);
        cyc(1'b1, 32'h10, ins(32'h10), 1'b0, 1'b0);
        chk("t2_full_count", {61'd0, count}, 64'd4);
        chk("t2_full_fetch_write", {63'd0, fetch_write}, 64'd0);
        cyc(1'b1, 32'h10, ins(32'h10), 1'b1, 1'b0);
        chk("t2_pop_full_fetch_write", {63'd0, fetch_write}, 64'd0);
        idle(1'b0);
        chk("t2_after_pop_fetch_write", {63'd0, fetch_write}, 64'd1);
        chk("t2_after_pop_count", {61'd0, count}, 64'd3);
        drain();

        // ordered stream across the pointer wrap, fetch holds each pc until accepted
        sent = 0;
        for (int i = 0; i < 60 && sent < 10; i++) begin
            cyc(1'b1, 32'(sent * 4), ins(32'(sent * 4)), i[0], 1'b0);
            if (last_acc) sent++;
        end
        chk("t3_all_sent", 64'(sent), 64'd10);
        drain();

        // simultaneous push and pop at count 2
        cyc(1'b1, 32'hA0, ins(32'hA0), 1'b0, 1'b0);
        cyc(1'b1, 32'hA4, ins(32'hA4), 1'b0, 1'b0);
        cyc(1'b1, 32'hA8, ins(32'hA8), 1'b1, 1'b0);
        chk("t4_count_c1", {61'd0, count}, 64'd2);
        chk("t4_pc_c1", {32'd0, out_pc}, 64'hA0);
        cyc(1'b1, 32'hAC, ins(32'hAC), 1'b1, 1'b0);
        chk("t4_count_c2", {61'd0, count}, 64'd2);
        chk("t4_pc_c2", {32'd0, out_pc}, 64'hA4);
        cyc(1'b1, 32'hB0, ins(32'hB0), 1'b1, 1'b0);
        chk("t4_count_c3", {61'd0, count}, 64'd2);
        chk("t4_pc_c3", {32'd0, out_pc}, 64'hA8);
        idle(1'b0);
        chk("t4_count_end", {61'd0, count}, 64'd2);
        chk("t4_pc_end", {32'd0, out_pc}, 64'hAC);
        drain();

        // flush wins over a same-cycle push and pop
        cyc(1'b1, 32'hC0, ins(32'hC0), 1'b0, 1'b0);
        cyc(1'b1, 32'hC4, ins(32'hC4), 1'b0, 1'b0);
        cyc(1'b1, 32'hC8, ins(32'hC8), 1'b0, 1'b0);
        cyc(1'b1, 32'h40, ins(32'h40), 1'b1, 1'b1);
        chk("t5_pre_count", {61'd0, count}, 64'd3);
        idle(1'b1);
        chk("t5_count", {61'd0, count}, 64'd0);
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_out_pc", {32'd0, out_pc}, 64'd0);
        chk("t5_fetch_write", {63'd0, fetch_write}, 64'd1);
        idle(1'b1);

        // push into an empty queue with decode ready
        cyc(1'b1, 32'h100, ins(32'h100), 1'b1, 1'b0);
        chk("t6_same_out_valid", {63'd0, out_valid}, BYP ? 64'd1 : 64'd0);
        chk("t6_same_out_pc", {32'd0, out_pc}, BYP ? 64'h100 : 64'd0);
        idle(1'b0);
        chk("t6_next_count", {61'd0, count}, BYP ? 64'd0 : 64'd1);
        chk("t6_next_out_pc", {32'd0, out_pc}, BYP ? 64'd0 : 64'h100);
        drain();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Small instruction FIFO between the instruction-fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair and presents entries to decode in order.
- Back-pressures fetch through a PC write-enable.
- Discards all held entries on a branch flush so that decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4: number of entries; must be a power of two, minimum 2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- fetch_write  output  1  ready to fetch; drives the fetch-stage PC write-enable; equals (count != DEPTH).
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  PC of the head entry; 0 when out_valid=0.
- out_instr  output  32  instruction of the head entry; 0 when out_valid=0.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  branch resolved taken; discard all entries.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit entries, plus wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH naturally.
- Reset (synchronous, reset=1 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, out_pc=0, out_instr=0, fetch_write=1.
  - Entry contents are don't-care.
- Push: occurs when in_valid && fetch_write && !flush. Writes {in_pc, in_instr} at wr_ptr, then wr_ptr+1.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr+1.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: unchanged.
- Latency: a pushed entry is visible on out_* in the cycle after the push edge (1-cycle latency).
- Output decode:
  - out_valid = (count != 0).
  - out_pc and out_instr come from the entry at rd_ptr, gated to 0 when empty.
- Full (count == DEPTH):
  - fetch_write=0, so fetch holds its PC.
  - A pop in the same cycle does not re-open the push path that cycle; there is no combinational out_ready-to-fetch_write path.
  - fetch_write returns to 1 the cycle after the pop.
- Empty (count == 0):
  - out_valid=0 and out_ready is ignored.
  - A simultaneous push on an empty queue stores the entry; it appears next cycle.
- Flush:
  - Highest priority after reset. At the edge, wr_ptr, rd_ptr and count go to 0.
  - Any in_valid and out_ready in that cycle are ignored; neither a push nor a pop occurs.
  - The cycle after a flush: out_valid=0 and fetch_write=1.
- Reset during operation overrides flush, push and pop; the result is identical to the power-on reset state.
- in_valid while fetch_write=0: the pair is not stored. Fetch is responsible for holding it.
- No X propagation: out_pc and out_instr are never driven from an unwritten entry.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and flush=0, the queue drives out_valid=1, out_pc=in_pc, out_instr=in_instr combinationally in the same cycle.
  - If out_ready=1 in that cycle, the pair is consumed and not written; count stays 0.
  - If out_ready=0, the pair is written normally.
- Not defined: behaviour is exactly as above, with a strict 1-cycle latency and no combinational path from in_* to out_*.

Test Plan:
1. Reset, then single push: assert reset for 2 cycles, then push in_pc=0x0, in_instr=0x00A00093 with out_ready=0.
   - Next cycle: out_valid=1, out_pc=0x0, out_instr=0x00A00093, count=1.
2. Fill to full: push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0.
   - After the 4th edge: count=4, fetch_write=0.
   - A 5th in_valid with PC 0x10 is not stored.
   - Pop one: fetch_write=1 on the following cycle.
3. Ordering and wrap: stream 10 pushes (PC 0x0..0x24, step 4) with out_ready toggling every cycle.
   - Decode sees PCs strictly in order 0x0, 0x4, ..., 0x24 with no duplicates or drops, crossing the pointer wrap.
4. Simultaneous push and pop: hold count=2, then in_valid=1 and out_ready=1 for 3 cycles.
   - count stays 2.
   - Outputs advance one entry per cycle.
5. Flush priority: count=3, in the same cycle as flush=1 also assert in_valid=1 (PC 0x40) and out_ready=1.
   - Next cycle: count=0, out_valid=0, out_pc=0, fetch_write=1.
   - PC 0x40 never appears on the output.
6. Bypass (only with FETCH_QUEUE_BYPASS_EN): empty queue, in_valid=1, in_pc=0x100, out_ready=1.
   - Same cycle: out_valid=1, out_pc=0x100.
   - Next cycle: count=0.
   - Without the macro: out_valid=0 that cycle; next cycle out_pc=0x100 and count=1.
